// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the ID-stage register bank.
package regbank_pkg;

  // Clear sequencer state: CLEAR zeroes the array after reset, RUN is normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regbank_state_e;

  localparam int REGBANK_DATA_W = 32;
  localparam int REGBANK_DEPTH  = 32;
  localparam int REGBANK_NUM_RD = 2;

endpackage

// File: rtl/regbank_clear_fsm.sv
// Post-reset clear sequencer: walks clr_addr from 0 to DEPTH-1, one entry per cycle,
// asserting clr_we, then settles in RUN. busy is high for the whole walk.
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int DEPTH  = REGBANK_DEPTH,
  parameter int ADDR_W = $clog2(REGBANK_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  regbank_state_e    state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  // State register; reset (also mid-clear) restarts the walk at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // Next state: advance the pointer until the last entry, then hand over to RUN.
  // The pointer holds at DEPTH-1 instead of wrapping.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (state == CLEAR) begin
      if (clr_ptr == LAST_ADDR) begin
        state_nxt = RUN;
      end else begin
        clr_ptr_nxt = clr_ptr + 1'b1;
      end
    end
  end

  // Outputs: a zero write to the current pointer on every CLEAR cycle.
  always_comb begin
    busy     = (state == CLEAR);
    clr_we   = (state == CLEAR);
    clr_addr = clr_ptr;
  end

endmodule

// File: rtl/register_bank.sv
// ID-stage register file: NUM_RD registered read ports, one WB write port,
// same-edge write-to-read bypass, optional hardwired-zero entry 0, and a
// post-reset clear sequence that zeroes the array one entry per cycle.
// Optional feature macro: REGBANK_DEBUG_PORT_EN adds i_dbg_addr/o_dbg_data,
// a registered debug read port with the same bypass and zero rules.
module register_bank
  import regbank_pkg::*;
#(
  parameter int DATA_W   = REGBANK_DATA_W,
  parameter int DEPTH    = REGBANK_DEPTH,
  parameter int ADDR_W   = $clog2(REGBANK_DEPTH),
  parameter int NUM_RD   = REGBANK_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_wenable,
  input  logic [ADDR_W-1:0]        i_addr_wr,
  input  logic [DATA_W-1:0]        i_data_wr,
  input  logic [NUM_RD*ADDR_W-1:0] i_addr_rd,
  output logic [NUM_RD*DATA_W-1:0] o_data_rd,
  output logic                     o_busy
`ifdef REGBANK_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]        i_dbg_addr,
  output logic [DATA_W-1:0]        o_dbg_data
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              wr_run;

  regbank_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset    (i_reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign o_busy = busy;

  // True for the hardwired-zero entry; such an address never stores or bypasses data.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Read-port value for address a: zero entry first, then bypass of a same-edge
  // WB write, otherwise the stored entry. Shared by every read port.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] a,
    input logic              wr,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    if (is_zero(a)) return '0;
    if (wr && (a == wa)) return wd;
    return stored;
  endfunction

  // WB writes only count in RUN; reset overrides both the clear and WB writes.
  assign wr_run = i_wenable && !busy && !i_reset;

  // Array write-port mux: clear sequencer owns the port during CLEAR, WB during RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = i_addr_wr;
    arr_wdata = i_data_wr;
    if (!i_reset) begin
      if (busy) begin
        arr_we    = clr_we;
        arr_waddr = clr_addr;
        arr_wdata = '0;
      end else begin
        arr_we    = i_wenable && !is_zero(i_addr_wr);
      end
    end
  end

  // Storage array; data only, no reset (the clear sequencer zeroes it).
  always_ff @(posedge clk) begin
    if (arr_we) begin
      mem[arr_waddr] <= arr_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p1;

    assign addr_p0 = i_addr_rd[k*ADDR_W +: ADDR_W];

    // ---- stage p0 -> p1: registered read with bypass, forced to 0 while clearing
    always_ff @(posedge clk) begin
      if (i_reset || busy) begin
        data_p1 <= '0;
      end else begin
        data_p1 <= read_sel(addr_p0, wr_run, i_addr_wr, i_data_wr, mem[addr_p0]);
      end
    end

    assign o_data_rd[k*DATA_W +: DATA_W] = data_p1;
  end

`ifdef REGBANK_DEBUG_PORT_EN
  logic [DATA_W-1:0] dbg_p1;

  // ---- stage p0 -> p1: debug read, independent of the CPU read ports
  always_ff @(posedge clk) begin
    if (i_reset || busy) begin
      dbg_p1 <= '0;
    end else begin
      dbg_p1 <= read_sel(i_dbg_addr, wr_run, i_addr_wr, i_data_wr, mem[i_dbg_addr]);
    end
  end

  assign o_dbg_data = dbg_p1;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank (default parameters: 32x32, 2 read ports, ZERO_REG=1).
// Stimulus pushes expected responses tagged with the cycle they appear; a monitor
// on the falling edge pops and compares them against the DUT outputs.
module tb_register_bank;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_wenable = 1'b0;
  logic [AW-1:0]    i_addr_wr = '0;
  logic [DW-1:0]    i_data_wr = '0;
  logic [NR*AW-1:0] i_addr_rd = '0;
  logic [NR*DW-1:0] o_data_rd;
  logic             o_busy;
`ifdef REGBANK_DEBUG_PORT_EN
  logic [AW-1:0]    i_dbg_addr = '0;
  logic [DW-1:0]    o_dbg_data;
`endif

  register_bank dut (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_wenable (i_wenable),
    .i_addr_wr (i_addr_wr),
    .i_data_wr (i_data_wr),
    .i_addr_rd (i_addr_rd),
    .o_data_rd (o_data_rd),
    .o_busy    (o_busy)
`ifdef REGBANK_DEBUG_PORT_EN
    ,
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = read port, 1 = busy, 2 = debug port
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(string n, int kind, int port, logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = kind; e.port = port; e.exp = v; e.due = cyc + 1;
    q.push_back(e);
  endtask

  task automatic exp_rd(string n, int port, logic [31:0] v);
    push(n, 0, port, v);
  endtask

  task automatic exp_busy(string n, logic b);
    push(n, 1, 0, {31'b0, b});
  endtask

  task automatic drive(logic rst, logic we, int wa, logic [31:0] wd, int a0, int a1);
    i_reset   = rst;
    i_wenable = we;
    i_addr_wr = AW'(wa);
    i_data_wr = wd;
    i_addr_rd = {AW'(a1), AW'(a0)};
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every expectation that falls due after the latest rising edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      act = 'x;
      case (e.kind)
        0: act = o_data_rd[e.port*DW +: DW];
        1: act = {31'b0, o_busy};
`ifdef REGBANK_DEBUG_PORT_EN
        2: act = o_dbg_data;
`endif
        default: act = 'x;
      endcase
      if (e.due != cyc) begin
        errors++;
        $display("FAIL %s: stale expectation (due cycle %0d, now %0d) got 0x%08h expected 0x%08h",
                 e.name, e.due, cyc, act, e.exp);
      end else if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // Reset one cycle: busy and read data go to their reset values.
    drive(1, 0, 0, 0, 3, 4);
    exp_busy("rst_busy", 1'b1);
    exp_rd("rst_p0", 0, 0);
    exp_rd("rst_p1", 1, 0);
    cycle();

    // Clear walk: busy high for 32 edges, reads held 0, WB writes ignored.
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, (i + 31) % 32, 32'hFFFF_FFFF, (i + 31) % 32, i);
      exp_busy("clr_busy", (i < 31));
      exp_rd("clr_hold_p0", 0, 0);
      cycle();
    end

    // Every address reads zero on both ports after the clear.
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, i, (i + 16) % 32);
      exp_rd("sweep_p0", 0, 0);
      exp_rd("sweep_p1", 1, 0);
      exp_busy("run_busy", 1'b0);
      cycle();
    end

    // Write r5, read it back the next cycle.
    drive(0, 1, 5, 32'hDEAD_BEEF, 0, 1);
    exp_rd("wr5_p0", 0, 0);
    exp_rd("wr5_p1", 1, 0);
    cycle();
    drive(0, 0, 0, 0, 5, 6);
    exp_rd("rd5_p0", 0, 32'hDEAD_BEEF);
    exp_rd("rd6_p1", 1, 0);
    cycle();

    // Bypass: old value 0x11111111 in r7, then overwrite while both ports read r7.
    drive(0, 1, 7, 32'h1111_1111, 7, 5);
    exp_rd("byp_first_p0", 0, 32'h1111_1111);
    exp_rd("byp_other_p1", 1, 32'hDEAD_BEEF);
    cycle();
    drive(0, 1, 7, 32'h1234_5678, 7, 7);
    exp_rd("byp_r7_p0", 0, 32'h1234_5678);
    exp_rd("byp_r7_p1", 1, 32'h1234_5678);
    cycle();
    drive(0, 0, 0, 0, 7, 5);
    exp_rd("after_byp_p0", 0, 32'h1234_5678);
    exp_rd("after_byp_p1", 1, 32'hDEAD_BEEF);
    cycle();

    // Bypass only on the port whose address matches.
    drive(0, 1, 9, 32'hCAFE_F00D, 5, 9);
    exp_rd("indep_p0", 0, 32'hDEAD_BEEF);
    exp_rd("indep_p1", 1, 32'hCAFE_F00D);
    cycle();

    // Entry 0 hardwired: write dropped, no bypass.
    drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0);
    exp_rd("r0_byp_p0", 0, 0);
    exp_rd("r0_byp_p1", 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 9);
    exp_rd("r0_next_p0", 0, 0);
    exp_rd("r9_p1", 1, 32'hCAFE_F00D);
    cycle();

`ifdef REGBANK_DEBUG_PORT_EN
    // Debug port: bypass on the write edge, stored value next edge, zero entry.
    drive(0, 1, 31, 32'h0000_0055, 5, 5);
    i_dbg_addr = 5'd31;
    push("dbg_byp", 2, 0, 32'h0000_0055);
    exp_rd("dbg_undisturbed_p0", 0, 32'hDEAD_BEEF);
    cycle();
    drive(0, 0, 0, 0, 31, 0);
    i_dbg_addr = 5'd31;
    push("dbg_r31", 2, 0, 32'h0000_0055);
    exp_rd("dbg_p0_r31", 0, 32'h0000_0055);
    cycle();
    drive(0, 1, 0, 32'h0000_00AA, 0, 0);
    i_dbg_addr = 5'd0;
    push("dbg_r0", 2, 0, 0);
    cycle();
`endif

    // Reset mid-clear restarts the walk from entry 0.
    drive(0, 1, 20, 32'hA5A5_A5A5, 1, 1);
    cycle();
    drive(0, 0, 0, 0, 20, 5);
    exp_rd("r20_set_p0", 0, 32'hA5A5_A5A5);
    exp_rd("r5_keep_p1", 1, 32'hDEAD_BEEF);
    cycle();
    drive(1, 1, 3, 32'h0000_0077, 20, 20);
    exp_busy("rst2_busy", 1'b1);
    exp_rd("rst2_p0", 0, 0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 20, 20);
      exp_busy("partial_busy", 1'b1);
      exp_rd("partial_p1", 1, 0);
      cycle();
    end
    drive(1, 0, 0, 0, 20, 20);
    exp_busy("rst3_busy", 1'b1);
    cycle();
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 20, 5);
      exp_busy("reclr_busy", (i < 31));
      cycle();
    end
    drive(0, 0, 0, 0, 20, 3);
    exp_rd("r20_cleared_p0", 0, 0);
    exp_rd("r3_cleared_p1", 1, 0);
    cycle();
    drive(0, 0, 0, 0, 5, 9);
    exp_rd("r5_cleared_p0", 0, 0);
    exp_rd("r9_cleared_p1", 1, 0);
    cycle();

    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
